// File: rtl/morra_scoreboard.sv
// morra_scoreboard: match-level scoreboard placed after the Morra Cinese FSMD.
// It keeps in-game round tallies, per-player game totals and a match-over
// decision, plus an optional show-ahead history FIFO of completed-game codes.
// Optional feature macro: SCOREBOARD_HISTORY_EN (defined -> history FIFO built;
// undefined -> the hist_* ports are kept but tied to constant zero).
`timescale 1ns/1ps

module morra_scoreboard #(
  parameter int CW         = 4,
  parameter int MATCH_WINS = 3,
  parameter int HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          match_clr,
  input  logic [1:0]                    round_in,
  input  logic [1:0]                    game_in,
  output logic [CW-1:0]                 p1_rounds,
  output logic [CW-1:0]                 p2_rounds,
  output logic [CW-1:0]                 rounds_played,
  output logic [CW-1:0]                 p1_games,
  output logic [CW-1:0]                 p2_games,
  output logic [CW-1:0]                 draw_games,
  output logic                          match_over,
  output logic [1:0]                    match_winner,
  input  logic                          hist_rd,
  output logic                          hist_valid,
  output logic [1:0]                    hist_data,
  output logic [$clog2(HIST_DEPTH):0]   hist_count,
  output logic                          hist_ovf
);

  localparam int AW  = $clog2(HIST_DEPTH);
  localparam int HCW = AW + 1;

  // Result codes shared by ROUND, GAME, the history entries and match_winner.
  typedef enum logic [1:0] {
    CODE_NONE = 2'b00,
    CODE_P1   = 2'b01,
    CODE_P2   = 2'b10,
    CODE_DRAW = 2'b11
  } code_e;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] WIN_TGT = CW'(MATCH_WINS);

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [CW-1:0] p1_rounds_q, p1_rounds_d;
  logic [CW-1:0] p2_rounds_q, p2_rounds_d;
  logic [CW-1:0] rounds_played_q, rounds_played_d;
  logic [CW-1:0] p1_games_q, p1_games_d;
  logic [CW-1:0] p2_games_q, p2_games_d;
  logic [CW-1:0] draw_games_q, draw_games_d;
  logic          match_over_q, match_over_d;
  logic [1:0]    match_winner_q, match_winner_d;

  // A completed game that was accepted; feeds the history FIFO.
  logic          hist_push;

  // Next-state for tallies and match decision: match_clr beats start beats events.
  always_comb begin
    p1_rounds_d     = p1_rounds_q;
    p2_rounds_d     = p2_rounds_q;
    rounds_played_d = rounds_played_q;
    p1_games_d      = p1_games_q;
    p2_games_d      = p2_games_q;
    draw_games_d    = draw_games_q;
    match_over_d    = match_over_q;
    match_winner_d  = match_winner_q;
    hist_push       = 1'b0;

    if (match_clr) begin
      p1_rounds_d     = '0;
      p2_rounds_d     = '0;
      rounds_played_d = '0;
      p1_games_d      = '0;
      p2_games_d      = '0;
      draw_games_d    = '0;
      match_over_d    = 1'b0;
      match_winner_d  = CODE_NONE;
    end else if (start) begin
      // New game: only the in-game tallies restart; same-cycle events are dropped.
      p1_rounds_d     = '0;
      p2_rounds_d     = '0;
      rounds_played_d = '0;
    end else if (!match_over_q) begin
      if (game_in != CODE_NONE) begin
        // A game result closes the game, so it wins over a simultaneous round.
        p1_rounds_d     = '0;
        p2_rounds_d     = '0;
        rounds_played_d = '0;
        hist_push       = 1'b1;
        case (game_in)
          CODE_P1: p1_games_d   = sat_inc(p1_games_q);
          CODE_P2: p2_games_d   = sat_inc(p2_games_q);
          default: draw_games_d = sat_inc(draw_games_q);
        endcase
        // Decide on the updated totals so match_over rises with the deciding game.
        if (p1_games_d == WIN_TGT) begin
          match_over_d   = 1'b1;
          match_winner_d = CODE_P1;
        end else if (p2_games_d == WIN_TGT) begin
          match_over_d   = 1'b1;
          match_winner_d = CODE_P2;
        end
      end else if (round_in != CODE_NONE) begin
        rounds_played_d = sat_inc(rounds_played_q);
        if (round_in == CODE_P1) begin
          p1_rounds_d = sat_inc(p1_rounds_q);
        end else if (round_in == CODE_P2) begin
          p2_rounds_d = sat_inc(p2_rounds_q);
        end
      end
    end
  end

  // Tally and match-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_rounds_q     <= '0;
      p2_rounds_q     <= '0;
      rounds_played_q <= '0;
      p1_games_q      <= '0;
      p2_games_q      <= '0;
      draw_games_q    <= '0;
      match_over_q    <= 1'b0;
      match_winner_q  <= CODE_NONE;
    end else begin
      p1_rounds_q     <= p1_rounds_d;
      p2_rounds_q     <= p2_rounds_d;
      rounds_played_q <= rounds_played_d;
      p1_games_q      <= p1_games_d;
      p2_games_q      <= p2_games_d;
      draw_games_q    <= draw_games_d;
      match_over_q    <= match_over_d;
      match_winner_q  <= match_winner_d;
    end
  end

  assign p1_rounds     = p1_rounds_q;
  assign p2_rounds     = p2_rounds_q;
  assign rounds_played = rounds_played_q;
  assign p1_games      = p1_games_q;
  assign p2_games      = p2_games_q;
  assign draw_games    = draw_games_q;
  assign match_over    = match_over_q;
  assign match_winner  = match_winner_q;

`ifdef SCOREBOARD_HISTORY_EN

  localparam logic [HCW-1:0] DEPTH_C = HCW'(HIST_DEPTH);

  logic [1:0]     mem_q [HIST_DEPTH];
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [HCW-1:0] count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           valid_q, valid_d;
  logic [1:0]     data_q, data_d;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic           fifo_full;
  logic           fifo_pop;

  assign fifo_full = (count_q == DEPTH_C);
  // Reads while empty are simply ignored.
  assign fifo_pop  = hist_rd && (count_q != '0);

  // FIFO pointer/occupancy update and show-ahead data for the next cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = tail_q;

    if (match_clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (hist_push) begin
        wr_en  = 1'b1;
        tail_d = tail_q + 1'b1;
      end
      if (hist_push && (fifo_pop || fifo_full)) begin
        // Either a real pop or an overwrite of the oldest entry: head moves,
        // occupancy holds. Only the overwrite without a pop loses data.
        head_d = head_q + 1'b1;
        if (!fifo_pop) begin
          ovf_d = 1'b1;
        end
      end else if (hist_push) begin
        count_d = count_q + 1'b1;
      end else if (fifo_pop) begin
        head_d  = head_q + 1'b1;
        count_d = count_q - 1'b1;
      end
    end

    // The entry under the new head may be the one being written this edge.
    valid_d = (count_d != '0);
    if (!valid_d) begin
      data_d = CODE_NONE;
    end else if (wr_en && (wr_addr == head_d)) begin
      data_d = game_in;
    end else begin
      data_d = mem_q[head_d];
    end
  end

  // Storage entries, one small register per slot.
  generate
    for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist_mem
      // Slot write when the tail points here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[gi] <= CODE_NONE;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          mem_q[gi] <= game_in;
        end
      end
    end
  endgenerate

  // FIFO control and registered output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= CODE_NONE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign hist_valid = valid_q;
  assign hist_data  = data_q;
  assign hist_count = count_q;
  assign hist_ovf   = ovf_q;

`else

  // History disabled: ports stay for drop-in compatibility, outputs are constant.
  logic unused_hist_sigs;
  assign unused_hist_sigs = hist_rd | hist_push;

  assign hist_valid = 1'b0;
  assign hist_data  = CODE_NONE;
  assign hist_count = '0;
  assign hist_ovf   = 1'b0;

`endif

endmodule

// File: tb/tb_morra_scoreboard.sv
// Testbench for morra_scoreboard: directed vectors with hand-computed
// expectations queued by the driver and checked by an independent monitor.
// Honours SCOREBOARD_HISTORY_EN: without it every hist_* expectation is zero.
`timescale 1ns/1ps

module tb_morra_scoreboard;

`ifdef SCOREBOARD_HISTORY_EN
  localparam bit HIST_ON = 1'b1;
`else
  localparam bit HIST_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       match_clr;
  logic [1:0] round_in;
  logic [1:0] game_in;
  logic [3:0] p1_rounds, p2_rounds, rounds_played;
  logic [3:0] p1_games, p2_games, draw_games;
  logic       match_over;
  logic [1:0] match_winner;
  logic       hist_rd;
  logic       hist_valid;
  logic [1:0] hist_data;
  logic [3:0] hist_count;
  logic       hist_ovf;

  morra_scoreboard #(
    .CW(4),
    .MATCH_WINS(3),
    .HIST_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .match_clr(match_clr),
    .round_in(round_in),
    .game_in(game_in),
    .p1_rounds(p1_rounds),
    .p2_rounds(p2_rounds),
    .rounds_played(rounds_played),
    .p1_games(p1_games),
    .p2_games(p2_games),
    .draw_games(draw_games),
    .match_over(match_over),
    .match_winner(match_winner),
    .hist_rd(hist_rd),
    .hist_valid(hist_valid),
    .hist_data(hist_data),
    .hist_count(hist_count),
    .hist_ovf(hist_ovf)
  );

  typedef struct packed {
    logic [3:0] p1r;
    logic [3:0] p2r;
    logic [3:0] rp;
    logic [3:0] p1g;
    logic [3:0] p2g;
    logic [3:0] dg;
    logic       mo;
    logic [1:0] mw;
    logic       hv;
    logic [1:0] hd;
    logic [3:0] hc;
    logic       ho;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(int p1r, int p2r, int rp, int p1g, int p2g, int dg,
                               int mo, int mw, int hv, int hd, int hc, int ho);
    snap_t s;
    s.p1r = 4'(p1r);
    s.p2r = 4'(p2r);
    s.rp  = 4'(rp);
    s.p1g = 4'(p1g);
    s.p2g = 4'(p2g);
    s.dg  = 4'(dg);
    s.mo  = 1'(mo);
    s.mw  = 2'(mw);
    s.hv  = HIST_ON ? 1'(hv) : 1'b0;
    s.hd  = HIST_ON ? 2'(hd) : 2'b00;
    s.hc  = HIST_ON ? 4'(hc) : 4'd0;
    s.ho  = HIST_ON ? 1'(ho) : 1'b0;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("p1r=%0d p2r=%0d rp=%0d p1g=%0d p2g=%0d dg=%0d mo=%0b mw=%b hv=%0b hd=%b hc=%0d ho=%0b",
                     s.p1r, s.p2r, s.rp, s.p1g, s.p2g, s.dg, s.mo, s.mw, s.hv, s.hd, s.hc, s.ho);
  endfunction

  task automatic push_exp(input string nm, input snap_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One clock of stimulus; expectation describes the outputs after that edge.
  task automatic txn(input string nm, input bit st, input bit clr,
                     input logic [1:0] r, input logic [1:0] g, input bit rd,
                     input snap_t e);
    @(negedge clk);
    start     = st;
    match_clr = clr;
    round_in  = r;
    game_in   = g;
    hist_rd   = rd;
    @(posedge clk);
    #1;
    push_exp(nm, e);
  endtask

  // Monitor: outputs are registered, so sample them on the falling edge.
  always @(negedge clk) begin
    snap_t act;
    snap_t e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = '{p1r: p1_rounds, p2r: p2_rounds, rp: rounds_played,
              p1g: p1_games, p2g: p2_games, dg: draw_games,
              mo: match_over, mw: match_winner, hv: hist_valid,
              hd: hist_data, hc: hist_count, ho: hist_ovf};
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got {%s} expected {%s}", nm, fmt(act), fmt(e));
      end else begin
        $display("[TB] ok   %s: {%s}", nm, fmt(act));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    match_clr = 1'b0;
    round_in  = 2'b00;
    game_in   = 2'b00;
    hist_rd   = 1'b0;
    push_exp("reset", mk(0,0,0, 0,0,0, 0,0, 0,0,0,0));
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Round tallies, then game results, start, match end and FIFO reads.
    txn("round_p1",    0,0, 2'b01,2'b00,0, mk(1,0,1, 0,0,0, 0,0, 0,0,0,0));
    txn("round_p2",    0,0, 2'b10,2'b00,0, mk(1,1,2, 0,0,0, 0,0, 0,0,0,0));
    txn("round_draw",  0,0, 2'b11,2'b00,0, mk(1,1,3, 0,0,0, 0,0, 0,0,0,0));
    txn("game_p1",     0,0, 2'b01,2'b01,0, mk(0,0,0, 1,0,0, 0,0, 1,1,1,0));
    txn("round_p2_b",  0,0, 2'b10,2'b00,0, mk(0,1,1, 1,0,0, 0,0, 1,1,1,0));
    txn("start_drop",  1,0, 2'b01,2'b00,0, mk(0,0,0, 1,0,0, 0,0, 1,1,1,0));
    txn("game_p1_2",   0,0, 2'b00,2'b01,0, mk(0,0,0, 2,0,0, 0,0, 1,1,2,0));
    txn("game_draw",   0,0, 2'b00,2'b11,0, mk(0,0,0, 2,0,1, 0,0, 1,1,3,0));
    txn("game_p1_win", 0,0, 2'b00,2'b01,0, mk(0,0,0, 3,0,1, 1,1, 1,1,4,0));
    txn("after_over",  0,0, 2'b01,2'b10,0, mk(0,0,0, 3,0,1, 1,1, 1,1,4,0));
    txn("pop_1",       0,0, 2'b00,2'b00,1, mk(0,0,0, 3,0,1, 1,1, 1,1,3,0));
    txn("pop_2",       0,0, 2'b00,2'b00,1, mk(0,0,0, 3,0,1, 1,1, 1,3,2,0));
    txn("clr_start",   1,1, 2'b01,2'b01,0, mk(0,0,0, 0,0,0, 0,0, 0,0,0,0));

    // Nine games fill and overflow the 8-deep history; no player reaches 3.
    txn("ovf_g1",      0,0, 2'b00,2'b11,0, mk(0,0,0, 0,0,1, 0,0, 1,3,1,0));
    txn("ovf_g2",      0,0, 2'b10,2'b01,0, mk(0,0,0, 1,0,1, 0,0, 1,3,2,0));
    txn("ovf_g3",      0,0, 2'b00,2'b10,0, mk(0,0,0, 1,1,1, 0,0, 1,3,3,0));
    txn("ovf_g4",      0,0, 2'b00,2'b11,0, mk(0,0,0, 1,1,2, 0,0, 1,3,4,0));
    txn("ovf_g5",      0,0, 2'b00,2'b01,0, mk(0,0,0, 2,1,2, 0,0, 1,3,5,0));
    txn("ovf_g6",      0,0, 2'b00,2'b10,0, mk(0,0,0, 2,2,2, 0,0, 1,3,6,0));
    txn("ovf_g7",      0,0, 2'b00,2'b11,0, mk(0,0,0, 2,2,3, 0,0, 1,3,7,0));
    txn("ovf_g8_full", 0,0, 2'b00,2'b11,0, mk(0,0,0, 2,2,4, 0,0, 1,3,8,0));
    txn("ovf_g9",      0,0, 2'b00,2'b11,0, mk(0,0,0, 2,2,5, 0,0, 1,1,8,1));
    txn("full_pushpop",0,0, 2'b00,2'b11,1, mk(0,0,0, 2,2,6, 0,0, 1,2,8,1));
    txn("pop_full",    0,0, 2'b00,2'b00,1, mk(0,0,0, 2,2,6, 0,0, 1,3,7,1));
    txn("round_again", 0,0, 2'b01,2'b00,0, mk(1,0,1, 2,2,6, 0,0, 1,3,7,1));

    // Asynchronous reset between clock edges, checked before the next rising edge.
    @(negedge clk);
    round_in = 2'b00;
    game_in  = 2'b00;
    hist_rd  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push_exp("async_reset", mk(0,0,0, 0,0,0, 0,0, 0,0,0,0));
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Empty-read, push+pop at occupancy one, and drain to empty.
    txn("rd_empty",    0,0, 2'b00,2'b00,1, mk(0,0,0, 0,0,0, 0,0, 0,0,0,0));
    txn("game_p2",     0,0, 2'b00,2'b10,0, mk(0,0,0, 0,1,0, 0,0, 1,2,1,0));
    txn("pushpop_one", 0,0, 2'b00,2'b01,1, mk(0,0,0, 1,1,0, 0,0, 1,1,1,0));
    txn("pop_last",    0,0, 2'b00,2'b00,1, mk(0,0,0, 1,1,0, 0,0, 0,0,0,0));

    @(negedge clk);
    hist_rd = 1'b0;
    game_in = 2'b00;

    // Bounded wait for the monitor to drain outstanding expectations.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/morra_scoreboard.md
# morra_scoreboard

Match-level scoreboard placed directly downstream of the Morra Cinese game FSMD. It samples the FSMD's per-move ROUND and GAME result codes every clock and keeps the running state of the match:
- in-game round tallies;
- game totals per player;
- a match-over decision once one player reaches a set number of game wins;
- an optional history FIFO of completed-game results, read out through a show-ahead handshake.

## Interface
- CW, 4: width of every counter; all counters saturate at 2^CW-1.
- MATCH_WINS, 3: game wins that end the match (1..2^CW-1).
- HIST_DEPTH, 8: history FIFO depth, power of two, at least 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  same START pulse that feeds the FSMD; clears in-game tallies.
- match_clr  in  1  synchronous clear of all match state, including the FIFO.
- round_in  in  2  FSMD ROUND: 00 none, 01 P1 round, 10 P2 round, 11 drawn round.
- game_in  in  2  FSMD GAME: 00 ongoing, 01 P1 game, 10 P2 game, 11 drawn game.
- p1_rounds, p2_rounds  out  CW  rounds won by each player in the current game.
- rounds_played  out  CW  decided and drawn rounds in the current game.
- p1_games, p2_games, draw_games  out  CW  completed-game totals.
- match_over  out  1  match decided; new events are ignored.
- match_winner  out  2  00 none, 01 P1, 10 P2.
- hist_rd  in  1  pop request for the history FIFO.
- hist_valid  out  1  FIFO not empty.
- hist_data  out  2  oldest stored game code (show-ahead).
- hist_count  out  $clog2(HIST_DEPTH)+1  FIFO occupancy.
- hist_ovf  out  1  sticky flag: an entry was overwritten.

## Operation
- Reset values: every counter is 0, match_over=0, match_winner=00, hist_valid=0, hist_data=00, hist_count=0, hist_ovf=0.
- Per-edge priority is match_clr, then start, then events.
  - match_clr: load all reset values and flush the FIFO.
  - start: clear p1_rounds, p2_rounds and rounds_played. Game totals, match state and the FIFO are kept. Events in the same cycle are dropped.
- An event is accepted only when match_over=0.
- Round event (round_in≠00):
  - rounds_played+1.
  - 01 adds 1 to p1_rounds; 10 adds 1 to p2_rounds; 11 adds to rounds_played only.
- Game event (game_in≠00):
  - Increment p1_games, p2_games or draw_games according to the code.
  - Clear the in-game tallies on the same edge. This overrides any round event in the same cycle.
  - Push game_in into the FIFO.
- Match decision: if the new p1_games or p2_games equals MATCH_WINS, set match_over and set match_winner to 01 or 10. Drawn games never end the match.
- All counters saturate and never wrap.
- FIFO behaviour:
  - Push when full: drop the oldest entry, store the new one, set hist_ovf.
  - Pop (hist_rd with hist_valid=1): advance the head.
  - hist_rd while empty is ignored.
  - Push and pop in the same cycle: both happen and the count is unchanged. When full, this does not set hist_ovf.
  - Head and tail pointers wrap modulo HIST_DEPTH.

## Timing
- Every output is registered. Each effect is visible one cycle after the edge that samples the input, with no combinational path from input to output.
- match_over rises on the same edge that updates the deciding game total.
- hist_data and hist_valid reflect a push on the following cycle. After a pop, the next entry is presented on the following cycle.
- A reset assertion in mid-game clears the state immediately, independent of clk. Deassertion is synchronised externally.

## Configuration
- SCOREBOARD_HISTORY_EN defined: the FIFO is built as described above.
- SCOREBOARD_HISTORY_EN undefined:
  - No FIFO storage is built, but the ports are kept.
  - hist_valid=0, hist_data=00, hist_count=0, hist_ovf=0 constantly; hist_rd is ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then round_in=01, 10, 11 in three consecutive cycles -> p1_rounds=1, p2_rounds=1, rounds_played=3, all game totals 0.
- Game event round_in=01 with game_in=01 -> p1_games=1, in-game tallies 0, hist_valid=1, hist_data=01, hist_count=1.
- Three P1 games with MATCH_WINS=3 -> match_over=1 and match_winner=01 one cycle after the third event; a later game_in=10 leaves p2_games=0 and hist_count=3.
- HIST_DEPTH=8, 9 games pushed (drawn games, match never ends) -> hist_count=8, hist_ovf=1, hist_data is the 2nd code pushed. Same-cycle push and pop when full -> count stays 8 and the head advances.
- start pulse in mid-game with round_in=01 -> tallies 0 and the round is dropped. match_clr with start -> every output returns to its reset value.
- Assert rst_n low between clock edges -> outputs reset immediately. With SCOREBOARD_HISTORY_EN undefined, hist_valid stays 0 through the whole game sequence.
